dram_port_arbiter: RTL
======================

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 26, DRAM address width {row,col,bank}.
- DATA_W, 128, burst data width.
- TIMEOUT_CYC, 1024, max cycles from grant to mc_ack.

REQ-002 Ports (name direction width meaning), clock and reset first:
- clk_i in 1: single clock.
- rst_i in 1: synchronous, active-high reset.
- p0_read in 1, p0_write in 1: port-0 request levels.
- p0_address in ADDR_W: port-0 address.
- p0_write_data in DATA_W: port-0 write data.
- p0_read_data out DATA_W: port-0 read data.
- p0_ack out 1: port-0 completion pulse.
- p1_read, p1_write, p1_address, p1_write_data, p1_read_data, p1_ack: identical set for port 1.
- mc_read out 1, mc_write out 1: controller request levels.
- mc_address out ADDR_W, mc_write_data out DATA_W: controller address and data.
- mc_read_data in DATA_W, mc_ack in 1, mc_busy in 1: controller response and init-busy.
- timeout_err out 1: sticky timeout flag.

Function
REQ-003 Every output SHALL be registered.
REQ-004 Requester handshake SHALL be: requester holds read or write level, with address and data stable, until its ack pulse; the requester drops its request in the cycle after ack.
REQ-005 Controller handshake SHALL be: arbiter holds mc_read or mc_write, with address and data stable, until mc_ack (1-cycle pulse).
REQ-006 FSM states SHALL be INIT, IDLE, ISSUE, GAP.
REQ-007 INIT SHALL hold all mc_* requests low and go to IDLE in the first cycle mc_busy=0.
REQ-008 In IDLE, if a request is pending, the arbiter SHALL latch the winner port, op, address and data, and go to ISSUE; mc_read/mc_write SHALL be asserted in the next cycle (1-cycle grant latency).
REQ-009 Round-robin SHALL apply: when both ports request, the port not in last_grant wins; a single requester wins immediately; last_grant updates at grant.
REQ-010 If one port asserts read and write together, write SHALL be served, one ack SHALL be given, and read SHALL be ignored.
REQ-011 In ISSUE, on mc_ack at cycle M:
- the read data SHALL be captured into the winner's pN_read_data (reads only; the other port's data is unchanged);
- pN_ack SHALL be high in cycle M+1 for exactly 1 cycle;
- mc request SHALL be low in M+1;
- the FSM SHALL go to GAP.
REQ-012 GAP SHALL last exactly 1 cycle with mc requests low, then go to IDLE; the minimum spacing between mc requests is 2 low cycles.
REQ-013 pN_read_data SHALL hold its value until the next read completion on the same port.
REQ-014 A requester withdrawing mid-transaction SHALL NOT abort it; the transaction completes and the ack is still pulsed.
REQ-015 A 16-bit timeout counter SHALL clear at grant and increment each ISSUE cycle.
REQ-016 When the counter reaches TIMEOUT_CYC without mc_ack:
- the mc request SHALL be dropped;
- the winner SHALL receive an ack with pN_read_data=0 (reads);
- timeout_err SHALL be set;
- the FSM SHALL go to GAP.
REQ-017 timeout_err SHALL clear only on reset.
REQ-018 mc_ack outside ISSUE SHALL be ignored.
REQ-019 An mc_ack coinciding with the timeout cycle SHALL count as a normal completion, with no error.

Reset
REQ-020 With rst_i=1 sampled at a clock edge, the next state SHALL be:
- state=INIT, last_grant=1 (port 0 wins the first tie);
- all mc_*=0, all pN_ack=0, pN_read_data=0, timeout_err=0, counter=0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction without an ack, and SHALL re-wait for mc_busy=0 before any new grant.

Verification
REQ-022 Reset, then mc_busy held high 50 cycles -> no mc request during that time; the first grant occurs only after mc_busy falls.
REQ-023 p0_write with address 0x0000123 and data 0xA5..A5; mc_ack after 20 cycles -> mc_write is 1 cycle after the request with matching address and data, p0_ack is one pulse in the cycle after mc_ack, and the p1 outputs are unchanged.
REQ-024 p0 and p1 read together, four back-to-back rounds -> grants alternate p0,p1,p0,p1; each pN_read_data equals the mc_read_data returned for its own grant.
REQ-025 Continuous p1 reads with p0 writing once -> p0 is granted at the next IDLE after the current p1 transaction.
REQ-026 mc_ack never returned, TIMEOUT_CYC=16 -> mc request drops after 16 ISSUE cycles; ack, read_data=0 and timeout_err=1; the next request is still served.
REQ-027 rst_i pulsed during ISSUE -> no ack; outputs at reset values the next cycle; the FSM is in INIT.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single DRAM controller port.
// Serves one transaction at a time and enforces a grant-to-ack timeout.
module dram_port_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_write_data,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_ack,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_write_data,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_ack,
    output logic              mc_read,
    output logic              mc_write,
    output logic [ADDR_W-1:0] mc_address,
    output logic [DATA_W-1:0] mc_write_data,
    input  logic [DATA_W-1:0] mc_read_data,
    input  logic              mc_ack,
    input  logic              mc_busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {INIT, IDLE, ISSUE, GAP} state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic                lastGrant_q, lastGrant_d;
    logic                winner_q, winner_d;
    logic                isWrite_q, isWrite_d;
    logic [15:0]         timeoutCnt_q, timeoutCnt_d;
    logic                mcRead_q, mcRead_d;
    logic                mcWrite_q, mcWrite_d;
    logic [ADDR_W-1:0]   mcAddress_q, mcAddress_d;
    logic [DATA_W-1:0]   mcWriteData_q, mcWriteData_d;
    logic [DATA_W-1:0]   p0ReadData_q, p0ReadData_d;
    logic [DATA_W-1:0]   p1ReadData_q, p1ReadData_d;
    logic                p0Ack_q, p0Ack_d;
    logic                p1Ack_q, p1Ack_d;
    logic                timeoutErr_q, timeoutErr_d;

    logic                pend0, pend1, pickP1, grantWrite, timeoutHit;
    logic [15:0]         cntInc;

    // On a tie the port that did not win last time is chosen; write beats read.
    assign pend0      = p0_read | p0_write;
    assign pend1      = p1_read | p1_write;
    assign pickP1     = pend1 & (~pend0 | ~lastGrant_q);
    assign grantWrite = pickP1 ? p1_write : p0_write;
    assign cntInc     = timeoutCnt_q + 16'd1;
    assign timeoutHit = (cntInc == TIMEOUT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= INIT;
            lastGrant_q   <= 1'b1;
            winner_q      <= 1'b0;
            isWrite_q     <= 1'b0;
            timeoutCnt_q  <= '0;
            mcRead_q      <= 1'b0;
            mcWrite_q     <= 1'b0;
            mcAddress_q   <= '0;
            mcWriteData_q <= '0;
            p0ReadData_q  <= '0;
            p1ReadData_q  <= '0;
            p0Ack_q       <= 1'b0;
            p1Ack_q       <= 1'b0;
            timeoutErr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lastGrant_q   <= lastGrant_d;
            winner_q      <= winner_d;
            isWrite_q     <= isWrite_d;
            timeoutCnt_q  <= timeoutCnt_d;
            mcRead_q      <= mcRead_d;
            mcWrite_q     <= mcWrite_d;
            mcAddress_q   <= mcAddress_d;
            mcWriteData_q <= mcWriteData_d;
            p0ReadData_q  <= p0ReadData_d;
            p1ReadData_q  <= p1ReadData_d;
            p0Ack_q       <= p0Ack_d;
            p1Ack_q       <= p1Ack_d;
            timeoutErr_q  <= timeoutErr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lastGrant_d   = lastGrant_q;
        winner_d      = winner_q;
        isWrite_d     = isWrite_q;
        timeoutCnt_d  = timeoutCnt_q;
        mcRead_d      = mcRead_q;
        mcWrite_d     = mcWrite_q;
        mcAddress_d   = mcAddress_q;
        mcWriteData_d = mcWriteData_q;
        p0ReadData_d  = p0ReadData_q;
        p1ReadData_d  = p1ReadData_q;
        p0Ack_d       = 1'b0;
        p1Ack_d       = 1'b0;
        timeoutErr_d  = timeoutErr_q;

        case (state_q)
            INIT: begin
                mcRead_d  = 1'b0;
                mcWrite_d = 1'b0;
                if (!mc_busy) state_d = IDLE;
            end
            IDLE: begin
                if (pend0 | pend1) begin
                    winner_d      = pickP1;
                    lastGrant_d   = pickP1;
                    isWrite_d     = grantWrite;
                    mcAddress_d   = pickP1 ? p1_address : p0_address;
                    mcWriteData_d = pickP1 ? p1_write_data : p0_write_data;
                    mcWrite_d     = grantWrite;
                    mcRead_d      = ~grantWrite;
                    timeoutCnt_d  = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                timeoutCnt_d = cntInc;
                // An ack arriving in the timeout cycle still counts as a clean completion.
                if (mc_ack || timeoutHit) begin
                    mcRead_d  = 1'b0;
                    mcWrite_d = 1'b0;
                    p0Ack_d   = ~winner_q;
                    p1Ack_d   = winner_q;
                    if (!isWrite_q) begin
                        if (winner_q) p1ReadData_d = mc_ack ? mc_read_data : '0;
                        else          p0ReadData_d = mc_ack ? mc_read_data : '0;
                    end
                    if (!mc_ack) timeoutErr_d = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign p0_read_data  = p0ReadData_q;
    assign p1_read_data  = p1ReadData_q;
    assign p0_ack        = p0Ack_q;
    assign p1_ack        = p1Ack_q;
    assign mc_read       = mcRead_q;
    assign mc_write      = mcWrite_q;
    assign mc_address    = mcAddress_q;
    assign mc_write_data = mcWriteData_q;
    assign timeout_err   = timeoutErr_q;

endmodule
